// File: rtl/ledsweep_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ledsweep_pkg
//  Description : Shared types and constants for the ledsweep_wb peripheral.
//  Revision    : 1.0 - initial release
// ============================================================================
package ledsweep_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_WRAP   = 2'd1,
        MODE_MANUAL = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEFT  = 3'd1,
        ST_RIGHT = 3'd2,
        ST_WRAP  = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_DIV    = 2'd1;
    localparam logic [1:0] c_ADDR_STATUS = 2'd2;
    localparam logic [1:0] c_ADDR_MAN    = 2'd3;

    localparam int c_CTRL_REPEAT_BIT = 2;
    localparam int c_STATUS_BUSY_BIT = 31;
    localparam int c_STATUS_POS_LSB  = 16;

    function automatic logic is_busy(input state_e s);
        return (s == ST_LEFT) || (s == ST_RIGHT) || (s == ST_WRAP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ledsweep_wb_if.sv
`default_nettype none
// ============================================================================
//  Module      : ledsweep_wb_if
//  Description : Pipelined Wishbone slave port bundle for ledsweep_wb.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ledsweep_wb_if;
    logic        i_cyc;
    logic        i_stb;
    logic        i_we;
    logic [1:0]  i_addr;
    logic [31:0] i_data;
    logic        o_stall;
    logic        o_ack;
    logic [31:0] o_data;

    modport slave (
        input  i_cyc, i_stb, i_we, i_addr, i_data,
        output o_stall, o_ack, o_data
    );

    modport master (
        output i_cyc, i_stb, i_we, i_addr, i_data,
        input  o_stall, o_ack, o_data
    );
endinterface
`default_nettype wire

// File: rtl/ledsweep_wb_tick_div.sv
`default_nettype none
// ============================================================================
//  Module      : tick_div
//  Description : Reloadable down-counter; ticks for one cycle when it hits 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_div #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_enable,
    input  logic [DIV_W-1:0] i_reload,
    output logic             o_tick
);
    logic [DIV_W-1:0] r_count;

    assign o_tick = i_enable && (r_count == '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load || o_tick) begin
            r_count <= i_reload;
        end else if (i_enable) begin
            r_count <= r_count - DIV_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/ledsweep_wb.sv
`default_nettype none
// ============================================================================
//  Module      : ledsweep_wb
//  Description : Wishbone LED sweeper with bounce/wrap/manual modes and a
//                one-cycle done interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module ledsweep_wb
    import ledsweep_pkg::*;
#(
    parameter int NLEDS       = 8,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    ledsweep_wb_if.slave     bus,
    output logic [NLEDS-1:0] o_led,
    output logic             o_int
);
    localparam int              PW        = $clog2(NLEDS);
    localparam logic [PW-1:0]   c_POS_MAX = PW'(NLEDS - 1);
    localparam logic [NLEDS-1:0] c_LED_ONE = NLEDS'(1);

    state_e            r_state, w_state_next;
    logic [PW-1:0]     r_pos, w_pos_next, w_pos_inc;
    logic [2:0]        r_ctrl;
    logic [DIV_W-1:0]  r_div;
    logic [NLEDS-1:0]  r_man, w_man_next, r_led, w_led_next;
    logic              r_int, w_done, r_ack;
    logic [31:0]       r_data, w_rdata;
    logic              w_wr, w_ctrl_wr, w_div_wr, w_man_wr;
    logic              w_busy, w_tick, w_repeat;
    mode_e             w_mode_wr;
    logic              w_unused;

    assign w_wr      = bus.i_stb && bus.i_we;
    assign w_ctrl_wr = w_wr && (bus.i_addr == c_ADDR_CTRL);
    assign w_div_wr  = w_wr && (bus.i_addr == c_ADDR_DIV);
    assign w_man_wr  = w_wr && (bus.i_addr == c_ADDR_MAN);
    assign w_mode_wr = mode_e'(bus.i_data[1:0]);
    assign w_busy    = is_busy(r_state);
    assign w_repeat  = r_ctrl[c_CTRL_REPEAT_BIT];
    assign w_pos_inc = r_pos + PW'(1);
    assign w_man_next = w_man_wr ? bus.i_data[NLEDS-1:0] : r_man;
    assign w_unused  = ^{bus.i_cyc, bus.i_data};

    tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (w_ctrl_wr),
        .i_enable (w_busy),
        .i_reload (r_div),
        .o_tick   (w_tick)
    );

    // A command write overrides any tick in the same cycle, so a terminal
    // tick coinciding with a write never raises the interrupt.
    always_comb begin
        w_state_next = r_state;
        w_pos_next   = r_pos;
        w_done       = 1'b0;
        if (w_ctrl_wr) begin
            w_pos_next = '0;
            case (w_mode_wr)
                MODE_BOUNCE: w_state_next = ST_LEFT;
                MODE_WRAP:   w_state_next = ST_WRAP;
                MODE_MANUAL: w_state_next = ST_HOLD;
                default:     w_state_next = ST_IDLE;
            endcase
        end else if (w_tick) begin
            case (r_state)
                ST_LEFT: begin
                    w_pos_next = w_pos_inc;
                    if (w_pos_inc == c_POS_MAX) begin
                        w_state_next = ST_RIGHT;
                    end
                end
                ST_RIGHT: begin
                    if (r_pos != '0) begin
                        w_pos_next = r_pos - PW'(1);
                    end else if (w_repeat) begin
                        w_state_next = ST_LEFT;
                        w_pos_next   = PW'(1);
                    end else begin
                        w_state_next = ST_IDLE;
                        w_done       = 1'b1;
                    end
                end
                ST_WRAP: begin
                    if (r_pos == c_POS_MAX) begin
                        w_pos_next = '0;
                        if (!w_repeat) begin
                            w_state_next = ST_IDLE;
                            w_done       = 1'b1;
                        end
                    end else begin
                        w_pos_next = w_pos_inc;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    // LEDs are decoded from the next state so the pattern lands with the state.
    always_comb begin
        w_led_next = '0;
        case (w_state_next)
            ST_LEFT, ST_RIGHT, ST_WRAP: w_led_next = c_LED_ONE << w_pos_next;
            ST_HOLD:                    w_led_next = w_man_next;
            default:                    w_led_next = '0;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (bus.i_addr)
            c_ADDR_CTRL: w_rdata[2:0] = r_ctrl;
            c_ADDR_DIV:  w_rdata[DIV_W-1:0] = r_div;
            c_ADDR_STATUS: begin
                w_rdata[c_STATUS_BUSY_BIT]         = w_busy;
                w_rdata[c_STATUS_POS_LSB +: PW]    = r_pos;
                w_rdata[NLEDS-1:0]                 = r_led;
            end
            default:     w_rdata[NLEDS-1:0] = r_man;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_pos   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pos   <= w_pos_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ctrl <= '0;
            r_div  <= DIV_W'(DEFAULT_DIV - 1);
            r_man  <= '0;
            r_led  <= '0;
            r_int  <= 1'b0;
            r_ack  <= 1'b0;
            r_data <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl <= bus.i_data[2:0];
            end
            if (w_div_wr) begin
                r_div <= bus.i_data[DIV_W-1:0];
            end
            r_man  <= w_man_next;
            r_led  <= w_led_next;
            r_int  <= w_done;
            r_ack  <= bus.i_stb;
            r_data <= (bus.i_stb && !bus.i_we) ? w_rdata : '0;
        end
    end

    assign bus.o_stall = 1'b0;
    assign bus.o_ack   = r_ack;
    assign bus.o_data  = r_data;
    assign o_led       = r_led;
    assign o_int       = r_int;

endmodule
`default_nettype wire

// File: tb/tb_ledsweep_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ledsweep_wb
//  Description : Self-checking bench for ledsweep_wb with a sweep-sequence model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ledsweep_wb;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] led;
    logic         irq;
    int           n_checks = 0;
    int           n_fail   = 0;

    ledsweep_wb_if bus();

    ledsweep_wb #(
        .NLEDS       (N),
        .DIV_W       (16),
        .DEFAULT_DIV (4)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave),
        .o_led   (led),
        .o_int   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Position of step k of a sweep: wrap counts modulo N, bounce walks a
    // triangle of period 2N-2.
    function automatic int pos_of(input int md, input int k);
        int p;
        int r;
        if (md == 1) return k % N;
        p = 2 * N - 2;
        r = k % p;
        return (r < N) ? r : p - r;
    endfunction

    logic        m_busy, m_hold, m_rep, m_term, m_int, m_ack;
    int          m_mode, m_k, m_wait, m_pos;
    logic [2:0]  m_ctrl;
    logic [15:0] m_div;
    logic [N-1:0] m_man, m_led;
    logic [31:0] m_rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_hold = 0; m_rep = 0; m_term = 0; m_int = 0; m_ack = 0;
            m_mode = 3; m_k = 0; m_wait = 0;
            m_ctrl = 0; m_div = 16'd3; m_man = 0; m_led = 0; m_rdata = 0;
        end else begin
            m_pos   = m_busy ? pos_of(m_mode, m_k) : 0;
            m_ack   = bus.i_stb;
            m_rdata = 0;
            if (bus.i_stb && !bus.i_we) begin
                case (bus.i_addr)
                    2'd0: m_rdata = {29'b0, m_ctrl};
                    2'd1: m_rdata = {16'b0, m_div};
                    2'd2: m_rdata = {m_busy, 11'b0, 4'(m_pos), 8'b0, m_led};
                    default: m_rdata = {24'b0, m_man};
                endcase
            end
            m_int  = 0;
            m_term = 0;
            if (m_busy) begin
                if (m_wait == 0) begin
                    if (!m_rep && ((m_mode == 0 && m_k == 2*N-2) || (m_mode == 1 && m_k == N-1)))
                        m_term = 1;
                    else begin
                        m_k++;
                        m_wait = int'(m_div);
                    end
                end else begin
                    m_wait--;
                end
            end
            if (bus.i_stb && bus.i_we) begin
                case (bus.i_addr)
                    2'd0: begin
                        m_ctrl = bus.i_data[2:0];
                        m_rep  = bus.i_data[2];
                        m_mode = int'(bus.i_data[1:0]);
                        m_busy = (m_mode < 2);
                        m_hold = (m_mode == 2);
                        m_k    = 0;
                        m_wait = int'(m_div);
                        m_term = 0;
                    end
                    2'd1: m_div = bus.i_data[15:0];
                    2'd3: m_man = bus.i_data[N-1:0];
                    default: ;
                endcase
            end
            if (m_term) begin
                m_busy = 0;
                m_int  = 1;
            end
            m_led = m_busy ? N'(1 << pos_of(m_mode, m_k)) : (m_hold ? m_man : '0);
        end
    end

    always @(negedge clk) begin
        check("led", 32'(led), 32'(m_led));
        check("int", 32'(irq), 32'(m_int));
        check("ack", 32'(bus.o_ack), 32'(m_ack));
        check("stall", 32'(bus.o_stall), 32'd0);
        if (m_ack) check("rdata", bus.o_data, m_rdata);
    end

    // Called at a negedge; returns at the negedge of the ack cycle.
    task automatic bus_cycle(input logic we, input logic [1:0] a, input logic [31:0] d,
                             output logic [31:0] rd);
        bus.i_cyc = 1; bus.i_stb = 1; bus.i_we = we; bus.i_addr = a; bus.i_data = d;
        @(posedge clk); #1;
        bus.i_cyc = 0; bus.i_stb = 0; bus.i_we = 0;
        @(negedge clk);
        rd = bus.o_data;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [N-1:0] exp_led;
        int nint;
        bus.i_cyc = 0; bus.i_stb = 0; bus.i_we = 0; bus.i_addr = 0; bus.i_data = 0;
        repeat (3) @(negedge clk);
        check("reset_led", 32'(led), 32'h0);
        check("reset_int", 32'(irq), 32'h0);
        check("reset_data", bus.o_data, 32'h0);
        rst = 0;
        @(negedge clk);

        bus_cycle(0, 2'd1, 0, rd);
        check("div_default", rd, 32'd3);

        // Bounce, DIV=0
        bus_cycle(1, 2'd1, 32'd0, rd);
        bus_cycle(1, 2'd0, 32'd0, rd);
        for (int i = 0; i < 15; i++) begin
            exp_led = (i < 8) ? N'(8'h01 << i) : N'(8'h80 >> (i - 7));
            check("bounce_seq", 32'(led), 32'(exp_led));
            @(negedge clk);
        end
        check("bounce_end_led", 32'(led), 32'h0);
        check("bounce_end_int", 32'(irq), 32'h1);
        @(negedge clk);
        check("bounce_int_one_cycle", 32'(irq), 32'h0);

        // Wrap, DIV=2
        bus_cycle(1, 2'd1, 32'd2, rd);
        bus_cycle(1, 2'd0, 32'd1, rd);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 3; j++) begin
                check("wrap_seq", 32'(led), 32'(8'h01 << i));
                @(negedge clk);
            end
        end
        check("wrap_end_led", 32'(led), 32'h0);
        check("wrap_end_int", 32'(irq), 32'h1);

        // Bounce + repeat, DIV=0, then OFF
        bus_cycle(1, 2'd1, 32'd0, rd);
        bus_cycle(1, 2'd0, 32'd4, rd);
        nint = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 8)  check("repeat_k8", 32'(led), 32'h40);
            if (k == 14) check("repeat_k14", 32'(led), 32'h01);
            if (k == 15) check("repeat_k15", 32'(led), 32'h02);
            if (irq) nint++;
            @(negedge clk);
        end
        check("repeat_no_int", nint, 0);
        bus_cycle(0, 2'd2, 0, rd);
        check("status_busy", 32'(rd[31]), 32'h1);
        bus_cycle(1, 2'd0, 32'd3, rd);
        check("off_led", 32'(led), 32'h0);
        check("off_int", 32'(irq), 32'h0);

        // Manual
        bus_cycle(1, 2'd3, 32'hA5, rd);
        bus_cycle(1, 2'd0, 32'd2, rd);
        check("man_a5", 32'(led), 32'hA5);
        bus_cycle(1, 2'd3, 32'h3C, rd);
        check("man_3c", 32'(led), 32'h3C);
        bus_cycle(0, 2'd2, 0, rd);
        check("man_status", rd, 32'h0000_003C);
        bus_cycle(0, 2'd0, 0, rd);
        check("ctrl_read", rd, 32'd2);
        bus_cycle(1, 2'd2, 32'hFFFF_FFFF, rd);
        bus_cycle(0, 2'd3, 0, rd);
        check("man_read", rd, 32'h3C);

        // Reset mid-bounce at pos 5
        bus_cycle(1, 2'd0, 32'd0, rd);
        repeat (5) @(negedge clk);
        check("pre_reset_pos5", 32'(led), 32'h20);
        #2 rst = 1;
        #1 check("async_reset_led", 32'(led), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        bus_cycle(0, 2'd1, 0, rd);
        check("reset_div", rd, 32'd3);
        bus_cycle(0, 2'd2, 0, rd);
        check("reset_status", rd, 32'h0);

        // CTRL write on the terminal tick of a wrap
        bus_cycle(1, 2'd1, 32'd0, rd);
        bus_cycle(1, 2'd0, 32'd1, rd);
        repeat (7) @(negedge clk);
        check("wrap_last", 32'(led), 32'h80);
        bus_cycle(1, 2'd0, 32'd0, rd);
        check("collide_led", 32'(led), 32'h01);
        check("collide_int", 32'(irq), 32'h0);
        nint = 0;
        for (int k = 0; k < 20; k++) begin
            if (irq) nint++;
            @(negedge clk);
        end
        check("collide_one_int", nint, 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
